// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL lock monitor.
// Combinational only; no latency, no backpressure.
package adpll_pkg;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } lock_state_e;

  localparam int SYNC_STAGES = 2;

  // Widest supported period counter is 16 bits; differences carry one extra bit.
  localparam int DIFF_W = 17;

  function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                 input logic [DIFF_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/adpll_lock_chan.sv
// One channel: input synchronisers, ref/fb period counters, period compare and lock FSM.
// Edge acted on 3 cycles after an input rise, FSM updates 1 cycle later; free-running, no backpressure.
module adpll_lock_chan
  import adpll_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int TOL         = 2,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_MISS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_raw,
  input  logic             fb_raw,
  output logic             lock,
  output lock_state_e      state,
  output logic [CNT_W-1:0] ref_period,
  output logic [CNT_W-1:0] fb_period,
  output logic             drop
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int XC_W = $clog2(UNLOCK_MISS + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Index 0 is the reference path, index 1 the feedback path.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [1:0]             prev_q;
  logic [1:0]             pulse;
  logic [1:0]             timeout;
  logic [CNT_W-1:0]       cnt_q [2];
  logic [CNT_W-1:0]       per_q [2];
  logic [1:0]             seen_q;
  logic [1:0]             vld_q;
  logic                   strobe_q;
  logic                   match;
  logic [DIFF_W-1:0]      ref_ext;
  logic [DIFF_W-1:0]      fb_ext;

  lock_state_e state_q, state_d;
  logic [MC_W-1:0] mcnt_q, mcnt_d;
  logic [XC_W-1:0] xcnt_q, xcnt_d;

  assign raw = {fb_raw, ref_raw};

  always_comb begin
    pulse   = '0;
    timeout = '0;
    for (int i = 0; i < 2; i++) begin
      pulse[i]   = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
      timeout[i] = (cnt_q[i] == CNT_SAT);
    end
  end

  // The first edge after reset or timeout only arms the path; its period is partial.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= CNT_ONE;
        per_q[i]  <= '0;
      end
      prev_q   <= '0;
      seen_q   <= '0;
      vld_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        prev_q[i] <= sync_q[i][SYNC_STAGES-1];
        if (pulse[i]) begin
          per_q[i]  <= cnt_q[i];
          cnt_q[i]  <= CNT_ONE;
          seen_q[i] <= 1'b1;
          if (seen_q[i]) vld_q[i] <= 1'b1;
        end else if (timeout[i]) begin
          seen_q[i] <= 1'b0;
          vld_q[i]  <= 1'b0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
      strobe_q <= pulse[0];
    end
  end

  assign ref_ext = DIFF_W'(per_q[0]);
  assign fb_ext  = DIFF_W'(per_q[1]);
  assign match   = vld_q[0] & vld_q[1] & (abs_diff(ref_ext, fb_ext) <= DIFF_W'(TOL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCK;
      mcnt_q  <= '0;
      xcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      xcnt_q  <= xcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    xcnt_d  = xcnt_q;
    if (|timeout) begin
      state_d = UNLOCK;
      mcnt_d  = '0;
      xcnt_d  = '0;
    end else if (strobe_q) begin
      case (state_q)
        UNLOCK: if (match) begin
          if (LOCK_CNT == 1) begin
            state_d = LOCKED;
          end else begin
            state_d = ACQ;
            mcnt_d  = MC_W'(1);
          end
        end
        ACQ: if (match) begin
          if (int'(mcnt_q) + 1 >= LOCK_CNT) begin
            state_d = LOCKED;
            mcnt_d  = '0;
          end else begin
            mcnt_d = mcnt_q + 1'b1;
          end
        end else begin
          state_d = UNLOCK;
          mcnt_d  = '0;
        end
        LOCKED: if (!match) begin
          if (UNLOCK_MISS == 1) begin
            state_d = UNLOCK;
          end else begin
            state_d = HOLD;
            xcnt_d  = XC_W'(1);
          end
        end
        HOLD: if (match) begin
          state_d = LOCKED;
          xcnt_d  = '0;
        end else if (int'(xcnt_q) + 1 >= UNLOCK_MISS) begin
          state_d = UNLOCK;
          xcnt_d  = '0;
        end else begin
          xcnt_d = xcnt_q + 1'b1;
        end
        default: state_d = UNLOCK;
      endcase
    end
  end

  assign lock       = (state_q == LOCKED) || (state_q == HOLD);
  assign drop       = lock & (state_d == UNLOCK);
  assign state      = state_q;
  assign ref_period = per_q[0];
  assign fb_period  = per_q[1];

endmodule

// File: rtl/adpll_lock_monitor.sv
// N-channel ADPLL frequency-lock monitor with registered per-channel readback and optional sticky LOL (ADPLL_LOL_STICKY_EN).
// Readback lags sel_i by 1 cycle; inputs are free-running, no backpressure.
module adpll_lock_monitor
  import adpll_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 12,
  parameter int TOL         = 2,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_MISS = 2,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk100_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  ref_i,
  input  logic [N_CH-1:0]  fb_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             lol_clr_i,
  output logic [N_CH-1:0]  lock_o,
  output logic [N_CH-1:0]  lol_o,
  output logic [CNT_W-1:0] sel_ref_period_o,
  output logic [CNT_W-1:0] sel_fb_period_o,
  output logic [1:0]       sel_state_o
);

  lock_state_e      chan_state [N_CH];
  logic [CNT_W-1:0] chan_ref   [N_CH];
  logic [CNT_W-1:0] chan_fb    [N_CH];
  logic [N_CH-1:0]  drop;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
    adpll_lock_chan #(
      .CNT_W      (CNT_W),
      .TOL        (TOL),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_MISS(UNLOCK_MISS)
    ) u_chan (
      .clk       (clk100_i),
      .rst       (rst_i),
      .ref_raw   (ref_i[ch]),
      .fb_raw    (fb_i[ch]),
      .lock      (lock_o[ch]),
      .state     (chan_state[ch]),
      .ref_period(chan_ref[ch]),
      .fb_period (chan_fb[ch]),
      .drop      (drop[ch])
    );
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      sel_ref_period_o <= '0;
      sel_fb_period_o  <= '0;
      sel_state_o      <= '0;
    end else if (int'(sel_i) < N_CH) begin
      sel_ref_period_o <= chan_ref[sel_i];
      sel_fb_period_o  <= chan_fb[sel_i];
      sel_state_o      <= chan_state[sel_i];
    end else begin
      sel_ref_period_o <= '0;
      sel_fb_period_o  <= '0;
      sel_state_o      <= '0;
    end
  end

`ifdef ADPLL_LOL_STICKY_EN
  // A new loss of lock outranks a concurrent clear so no event is lost.
  always_ff @(posedge clk100_i) begin
    if (rst_i) lol_o <= '0;
    else       lol_o <= (lol_o & ~{N_CH{lol_clr_i}}) | drop;
  end
`else
  logic unused_lol;
  assign unused_lol = ^{lol_clr_i, drop};
  assign lol_o      = '0;
`endif

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Directed bench for adpll_lock_monitor: vector table plus hand-written multi-cycle sequences.
module tb_adpll_lock_monitor;

`ifdef ADPLL_LOL_STICKY_EN
  localparam int LOL_EN = 1;
`else
  localparam int LOL_EN = 0;
`endif

  logic        clk100_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  ref_i = '0;
  logic [3:0]  fb_i = '0;
  logic [1:0]  sel_i = '0;
  logic        lol_clr_i = 1'b0;
  logic [3:0]  lock_o;
  logic [3:0]  lol_o;
  logic [11:0] sel_ref_period_o;
  logic [11:0] sel_fb_period_o;
  logic [1:0]  sel_state_o;

  adpll_lock_monitor dut (
    .clk100_i        (clk100_i),
    .rst_i           (rst_i),
    .ref_i           (ref_i),
    .fb_i            (fb_i),
    .sel_i           (sel_i),
    .lol_clr_i       (lol_clr_i),
    .lock_o          (lock_o),
    .lol_o           (lol_o),
    .sel_ref_period_o(sel_ref_period_o),
    .sel_fb_period_o (sel_fb_period_o),
    .sel_state_o     (sel_state_o)
  );

  always #5 clk100_i = ~clk100_i;

  // Square-wave sources, period in clk100_i cycles (0 = held low).
  int ref_per [4] = '{0, 0, 0, 0};
  int fb_per  [4] = '{0, 0, 0, 0};
  bit ref_rs  [4] = '{0, 0, 0, 0};
  bit fb_rs   [4] = '{0, 0, 0, 0};
  int rc      [4] = '{0, 0, 0, 0};
  int fc      [4] = '{0, 0, 0, 0};

  initial begin
    forever begin
      @(posedge clk100_i);
      #2;
      for (int ch = 0; ch < 4; ch++) begin
        if (ref_rs[ch]) begin
          rc[ch] = 0;
          ref_rs[ch] = 1'b0;
        end else if (ref_per[ch] != 0) begin
          rc[ch] = (rc[ch] + 1 >= ref_per[ch]) ? 0 : rc[ch] + 1;
        end
        if (fb_rs[ch]) begin
          fc[ch] = 0;
          fb_rs[ch] = 1'b0;
        end else if (fb_per[ch] != 0) begin
          fc[ch] = (fc[ch] + 1 >= fb_per[ch]) ? 0 : fc[ch] + 1;
        end
        ref_i[ch] = (ref_per[ch] != 0) && (rc[ch] < ref_per[ch] / 2);
        fb_i[ch]  = (fb_per[ch] != 0) && (fc[ch] < fb_per[ch] / 2);
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk100_i);
  endtask

  typedef struct {
    int       ch;
    int       rp;
    int       fp;
    bit       restart;
    int       wait_cyc;
    int       exp_lock;
    int       exp_state;
    int       exp_rp;
    int       exp_fp;
  } vec_t;

  vec_t vecs [6];

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    sel_i = 2'(v.ch);
    ref_per[v.ch] = v.rp;
    fb_per[v.ch]  = v.fp;
    if (v.restart) begin
      ref_rs[v.ch] = 1'b1;
      fb_rs[v.ch]  = 1'b1;
    end
    run(v.wait_cyc);
    check($sformatf("vec%0d_lock", i), int'(lock_o), v.exp_lock);
    check($sformatf("vec%0d_state", i), int'(sel_state_o), v.exp_state);
    check($sformatf("vec%0d_ref_period", i), int'(sel_ref_period_o), v.exp_rp);
    check($sformatf("vec%0d_fb_period", i), int'(sel_fb_period_o), v.exp_fp);
  endtask

  initial begin
    int  t_hold;
    int  t_fall;
    bit  saw_hold;

    //          ch  rp  fp  rst wait  lock     state rp  fp
    vecs[0] = '{0,  80, 80, 1,  600,  4'b0000, 1,    80, 80};  // ACQ after 7 matches
    vecs[1] = '{0,  80, 80, 0,  100,  4'b0001, 2,    80, 80};  // 8th match -> LOCKED
    vecs[2] = '{1,  80, 82, 1,  800,  4'b0011, 2,    80, 82};  // diff == TOL locks
    vecs[3] = '{1,  80, 83, 1,  1000, 4'b0001, 0,    80, 83};  // diff 3 never locks
    vecs[4] = '{2,  80, 80, 1,  750,  4'b0101, 2,    80, 80};
    vecs[5] = '{3,  80, 80, 1,  750,  4'b1101, 2,    80, 80};

    run(3);
    check("rst_lock", int'(lock_o), 0);
    check("rst_lol", int'(lol_o), 0);
    check("rst_sel_ref", int'(sel_ref_period_o), 0);
    check("rst_sel_fb", int'(sel_fb_period_o), 0);
    check("rst_sel_state", int'(sel_state_o), 0);
    rst_i = 1'b0;
    run(2);

    for (int i = 0; i < 3; i++) apply_vec(i);

    // ch1: fb stepped to 83 cycles -> HOLD, then UNLOCK one ref period later.
    fb_per[1] = 83;
    saw_hold = 1'b0;
    t_hold = -1000;
    t_fall = -1;
    for (int c = 0; c < 400; c++) begin
      run(1);
      if (!saw_hold && sel_state_o == 2'd3) begin
        saw_hold = 1'b1;
        t_hold = c;
        check("t2_lock_in_hold", int'(lock_o[1]), 1);
      end
      if (saw_hold && !lock_o[1]) begin
        t_fall = c;
        break;
      end
    end
    check("t2_hold_seen", int'(saw_hold), 1);
    check("t2_hold_to_unlock_cycles", t_fall - t_hold, 79);
    check("t2_lol_set", int'(lol_o[1]), LOL_EN);
    run(1);
    check("t2_state_unlock", int'(sel_state_o), 0);
    lol_clr_i = 1'b1;
    run(1);
    lol_clr_i = 1'b0;
    check("t2_lol_cleared", int'(lol_o[1]), 0);

    for (int i = 3; i < 6; i++) apply_vec(i);

    // ch2: fb stops; fb counter saturates and forces UNLOCK.
    sel_i = 2'd2;
    fb_per[2] = 0;
    t_fall = -1;
    for (int c = 0; c < 4400; c++) begin
      run(1);
      if (!lock_o[2]) begin
        t_fall = c;
        break;
      end
    end
    check("t3_timeout_in_window", int'(t_fall >= 3990 && t_fall <= 4110), 1);
    run(1);
    check("t3_state_unlock", int'(sel_state_o), 0);
    fb_per[2] = 80;
    fb_rs[2]  = 1'b1;
    run(75);
    check("t3_one_fb_edge_no_match", int'(sel_state_o), 0);
    run(100);
    check("t3_two_fb_edges_acq", int'(sel_state_o), 1);

    // ch3: unlock while lol_clr_i is held high.
    sel_i = 2'd3;
    lol_clr_i = 1'b1;
    fb_per[3] = 83;
    t_fall = -1;
    for (int c = 0; c < 400; c++) begin
      run(1);
      if (!lock_o[3]) begin
        t_fall = c;
        break;
      end
    end
    check("t6_unlock_seen", int'(t_fall >= 0), 1);
    check("t6_lol_set_wins", int'(lol_o[3]), LOL_EN);
    lol_clr_i = 1'b0;
    run(1);
    check("t6_lol_sticky", int'(lol_o[3]), LOL_EN);
    lol_clr_i = 1'b1;
    run(1);
    lol_clr_i = 1'b0;
    check("t6_lol_cleared", int'(lol_o[3]), 0);

    // One-cycle reset while ch0 is locked, then full relock.
    check("t5_pre_lock", int'(lock_o[0]), 1);
    rst_i = 1'b1;
    run(1);
    rst_i = 1'b0;
    check("t5_rst_lock", int'(lock_o), 0);
    check("t5_rst_lol", int'(lol_o), 0);
    check("t5_rst_sel_ref", int'(sel_ref_period_o), 0);
    check("t5_rst_sel_fb", int'(sel_fb_period_o), 0);
    check("t5_rst_sel_state", int'(sel_state_o), 0);
    run(549);
    check("t5_not_yet_relocked", int'(lock_o[0]), 0);
    run(250);
    check("t5_relocked", int'(lock_o[0]), 1);

    // Readback select switch 0 -> 3 takes effect one cycle later.
    sel_i = 2'd0;
    run(1);
    check("t6_sel0_state", int'(sel_state_o), 2);
    check("t6_sel0_fb", int'(sel_fb_period_o), 80);
    sel_i = 2'd3;
    #1;
    check("t6_sel3_same_cycle_state", int'(sel_state_o), 2);
    run(1);
    check("t6_sel3_state", int'(sel_state_o), 0);
    check("t6_sel3_fb", int'(sel_fb_period_o), 83);
    check("t6_sel3_ref", int'(sel_ref_period_o), 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
